// File: rtl/float_unit_arbiter_pkg.sv
// Shared types and constants for the float unit arbiter.
// One FSM encoding serves both the adder and the multiplier channel.
package float_unit_arbiter_pkg;

    localparam int FLOAT_W = 32;
    localparam int GNT_W   = 2;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_Z = 2'd2,
        ST_RETURN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/float_rr_channel.sv
// One round-robin channel: N_REQ requesters share one float unit.
// Requester and unit sides both use the STB/ACK handshake.
module float_rr_channel
    import float_unit_arbiter_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FLOAT_W*N_REQ-1:0] rq_a,
    input  logic [FLOAT_W*N_REQ-1:0] rq_b,
    input  logic [N_REQ-1:0]         rq_stb,
    output logic [N_REQ-1:0]         rq_ack,
    output logic [FLOAT_W-1:0]       rq_z,
    output logic [N_REQ-1:0]         rq_z_stb,
    input  logic [N_REQ-1:0]         rq_z_ack,
    output logic [FLOAT_W-1:0]       u_a,
    output logic [FLOAT_W-1:0]       u_b,
    output logic                     u_ab_stb,
    input  logic                     u_ab_ack,
    input  logic [FLOAT_W-1:0]       u_z,
    input  logic                     u_z_stb,
    output logic                     u_z_ack,
    output logic [GNT_W-1:0]         gnt
);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic [GNT_W-1:0]    ptr_q;
    logic [GNT_W-1:0]    gnt_q;
    logic [GNT_W-1:0]    pick;
    logic [GNT_W-1:0]    ptr_nxt;
    logic [N_REQ-1:0]    gnt_oh;
    logic [N_REQ-1:0]    pick_oh;
    logic [N_REQ-1:0]    ack_q;
    logic [FLOAT_W-1:0]  a_q;
    logic [FLOAT_W-1:0]  b_q;
    logic [FLOAT_W-1:0]  z_q;
    logic [FLOAT_W-1:0]  a_sel;
    logic [FLOAT_W-1:0]  b_sel;
    logic                z_ack_q;
    logic                ret_done;

    // Scan downward so the lowest offset from the pointer wins.
    function automatic logic [GNT_W-1:0] rr_pick(
        input logic [N_REQ-1:0] stb,
        input logic [GNT_W-1:0] ptr
    );
        logic [GNT_W-1:0] g;
        logic [N_REQ-1:0] sh;
        int               idx;
        g = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            sh = stb >> idx;
            if (sh[0]) g = GNT_W'(idx);
        end
        return g;
    endfunction

    assign pick     = rr_pick(rq_stb, ptr_q);
    assign pick_oh  = N_REQ'(1) << pick;
    assign gnt_oh   = N_REQ'(1) << gnt_q;
    assign a_sel    = FLOAT_W'(rq_a >> (FLOAT_W * int'(pick)));
    assign b_sel    = FLOAT_W'(rq_b >> (FLOAT_W * int'(pick)));
    assign ret_done = |(rq_z_ack & gnt_oh);
    assign ptr_nxt  = (int'(gnt_q) >= N_REQ - 1) ? '0
                                                 : gnt_q + GNT_W'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ARB:    if (|rq_stb)  state_d = ST_ISSUE;
            ST_ISSUE:  if (u_ab_ack) state_d = ST_WAIT_Z;
            ST_WAIT_Z: if (u_z_stb)  state_d = ST_RETURN;
            ST_RETURN: if (ret_done) state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            z_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= '0;
            z_ack_q <= 1'b0;
            if (state_q == ST_ARB && |rq_stb) begin
                gnt_q <= pick;
                a_q   <= a_sel;
                b_q   <= b_sel;
                ack_q <= pick_oh;
            end
            if (state_q == ST_WAIT_Z && u_z_stb) begin
                z_q     <= u_z;
                z_ack_q <= 1'b1;
            end
            if (state_q == ST_RETURN && ret_done) begin
                ptr_q <= ptr_nxt;
            end
        end
    end

    assign rq_ack   = ack_q;
    assign rq_z     = z_q;
    assign rq_z_stb = (state_q == ST_RETURN) ? gnt_oh : '0;
    assign u_a      = a_q;
    assign u_b      = b_q;
    assign u_ab_stb = (state_q == ST_ISSUE);
    assign u_z_ack  = z_ack_q;
    assign gnt      = gnt_q;

endmodule

// File: rtl/float_unit_arbiter.sv
// Shares one float adder and one float multiplier among N_REQ filters.
// The two channels are fully independent and may run concurrently.
module float_unit_arbiter
    import float_unit_arbiter_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                     i_CLK,
    input  logic                     i_RSTN,
    input  logic [FLOAT_W*N_REQ-1:0] i_RQ_ADD_A,
    input  logic [FLOAT_W*N_REQ-1:0] i_RQ_ADD_B,
    input  logic [N_REQ-1:0]         i_RQ_ADD_STB,
    output logic [N_REQ-1:0]         o_RQ_ADD_ACK,
    output logic [FLOAT_W-1:0]       o_RQ_ADD_Z,
    output logic [N_REQ-1:0]         o_RQ_ADD_Z_STB,
    input  logic [N_REQ-1:0]         i_RQ_ADD_Z_ACK,
    output logic [FLOAT_W-1:0]       o_ADD_A,
    output logic [FLOAT_W-1:0]       o_ADD_B,
    output logic                     o_ADD_AB_STB,
    input  logic                     i_ADD_AB_ACK,
    input  logic [FLOAT_W-1:0]       i_ADD_Z,
    input  logic                     i_ADD_Z_STB,
    output logic                     o_ADD_Z_ACK,
    output logic [GNT_W-1:0]         o_ADD_GNT,
    input  logic [FLOAT_W*N_REQ-1:0] i_RQ_MUL_A,
    input  logic [FLOAT_W*N_REQ-1:0] i_RQ_MUL_B,
    input  logic [N_REQ-1:0]         i_RQ_MUL_STB,
    output logic [N_REQ-1:0]         o_RQ_MUL_ACK,
    output logic [FLOAT_W-1:0]       o_RQ_MUL_Z,
    output logic [N_REQ-1:0]         o_RQ_MUL_Z_STB,
    input  logic [N_REQ-1:0]         i_RQ_MUL_Z_ACK,
    output logic [FLOAT_W-1:0]       o_MUL_A,
    output logic [FLOAT_W-1:0]       o_MUL_B,
    output logic                     o_MUL_AB_STB,
    input  logic                     i_MUL_AB_ACK,
    input  logic [FLOAT_W-1:0]       i_MUL_Z,
    input  logic                     i_MUL_Z_STB,
    output logic                     o_MUL_Z_ACK,
    output logic [GNT_W-1:0]         o_MUL_GNT
);

    float_rr_channel #(.N_REQ(N_REQ)) u_add_ch (
        .clk      (i_CLK),
        .rst_n    (i_RSTN),
        .rq_a     (i_RQ_ADD_A),
        .rq_b     (i_RQ_ADD_B),
        .rq_stb   (i_RQ_ADD_STB),
        .rq_ack   (o_RQ_ADD_ACK),
        .rq_z     (o_RQ_ADD_Z),
        .rq_z_stb (o_RQ_ADD_Z_STB),
        .rq_z_ack (i_RQ_ADD_Z_ACK),
        .u_a      (o_ADD_A),
        .u_b      (o_ADD_B),
        .u_ab_stb (o_ADD_AB_STB),
        .u_ab_ack (i_ADD_AB_ACK),
        .u_z      (i_ADD_Z),
        .u_z_stb  (i_ADD_Z_STB),
        .u_z_ack  (o_ADD_Z_ACK),
        .gnt      (o_ADD_GNT)
    );

    float_rr_channel #(.N_REQ(N_REQ)) u_mul_ch (
        .clk      (i_CLK),
        .rst_n    (i_RSTN),
        .rq_a     (i_RQ_MUL_A),
        .rq_b     (i_RQ_MUL_B),
        .rq_stb   (i_RQ_MUL_STB),
        .rq_ack   (o_RQ_MUL_ACK),
        .rq_z     (o_RQ_MUL_Z),
        .rq_z_stb (o_RQ_MUL_Z_STB),
        .rq_z_ack (i_RQ_MUL_Z_ACK),
        .u_a      (o_MUL_A),
        .u_b      (o_MUL_B),
        .u_ab_stb (o_MUL_AB_STB),
        .u_ab_ack (i_MUL_AB_ACK),
        .u_z      (i_MUL_Z),
        .u_z_stb  (i_MUL_Z_STB),
        .u_z_ack  (o_MUL_Z_ACK),
        .gnt      (o_MUL_GNT)
    );

endmodule

// File: tb/tb_float_unit_arbiter.sv
// Directed bench for float_unit_arbiter; the bench plays the float units
// and the requesters, with hand-computed expected values.
module tb_float_unit_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic [32*N-1:0] rq_add_a, rq_add_b, rq_mul_a, rq_mul_b;
    logic [N-1:0]  rq_add_stb, rq_add_ack, rq_add_z_stb, rq_add_z_ack;
    logic [N-1:0]  rq_mul_stb, rq_mul_ack, rq_mul_z_stb, rq_mul_z_ack;
    logic [31:0]   rq_add_z, rq_mul_z;
    logic [31:0]   add_a, add_b, add_z, mul_a, mul_b, mul_z;
    logic          add_ab_stb, add_ab_ack, add_z_stb, add_z_ack;
    logic          mul_ab_stb, mul_ab_ack, mul_z_stb, mul_z_ack;
    logic [1:0]    add_gnt, mul_gnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    float_unit_arbiter #(.N_REQ(N)) dut (
        .i_CLK          (clk),
        .i_RSTN         (rstn),
        .i_RQ_ADD_A     (rq_add_a),
        .i_RQ_ADD_B     (rq_add_b),
        .i_RQ_ADD_STB   (rq_add_stb),
        .o_RQ_ADD_ACK   (rq_add_ack),
        .o_RQ_ADD_Z     (rq_add_z),
        .o_RQ_ADD_Z_STB (rq_add_z_stb),
        .i_RQ_ADD_Z_ACK (rq_add_z_ack),
        .o_ADD_A        (add_a),
        .o_ADD_B        (add_b),
        .o_ADD_AB_STB   (add_ab_stb),
        .i_ADD_AB_ACK   (add_ab_ack),
        .i_ADD_Z        (add_z),
        .i_ADD_Z_STB    (add_z_stb),
        .o_ADD_Z_ACK    (add_z_ack),
        .o_ADD_GNT      (add_gnt),
        .i_RQ_MUL_A     (rq_mul_a),
        .i_RQ_MUL_B     (rq_mul_b),
        .i_RQ_MUL_STB   (rq_mul_stb),
        .o_RQ_MUL_ACK   (rq_mul_ack),
        .o_RQ_MUL_Z     (rq_mul_z),
        .o_RQ_MUL_Z_STB (rq_mul_z_stb),
        .i_RQ_MUL_Z_ACK (rq_mul_z_ack),
        .o_MUL_A        (mul_a),
        .o_MUL_B        (mul_b),
        .o_MUL_AB_STB   (mul_ab_stb),
        .i_MUL_AB_ACK   (mul_ab_ack),
        .i_MUL_Z        (mul_z),
        .i_MUL_Z_STB    (mul_z_stb),
        .o_MUL_Z_ACK    (mul_z_ack),
        .o_MUL_GNT      (mul_gnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #3;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // Unit accepts operands, returns res, requester g takes the result.
    task automatic serve_add(input int g, input logic [31:0] res);
        add_ab_ack = 1'b1;
        tick();
        add_ab_ack = 1'b0;
        chk("srv_ab_drop", 32'(add_ab_stb), 32'd0);
        add_z      = res;
        add_z_stb  = 1'b1;
        tick();
        add_z_stb  = 1'b0;
        chk("srv_z", rq_add_z, res);
        chk("srv_z_stb", 32'(rq_add_z_stb), 32'(3'b001 << g));
        rq_add_z_ack[g] = 1'b1;
        tick();
        rq_add_z_ack = '0;
        chk("srv_z_stb_drop", 32'(rq_add_z_stb), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        rq_add_a = '0; rq_add_b = '0; rq_add_stb = '0; rq_add_z_ack = '0;
        rq_mul_a = '0; rq_mul_b = '0; rq_mul_stb = '0; rq_mul_z_ack = '0;
        add_ab_ack = 1'b0; add_z = '0; add_z_stb = 1'b0;
        mul_ab_ack = 1'b0; mul_z = '0; mul_z_stb = 1'b0;
        #2;
        chk("rst_add_ack", 32'(rq_add_ack), 32'd0);
        chk("rst_add_ab_stb", 32'(add_ab_stb), 32'd0);
        chk("rst_add_gnt", 32'(add_gnt), 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_mul_z", rq_mul_z, 32'd0);
        do_reset();

        // Single add: 1.0 + 2.0 = 3.0
        rq_add_a[31:0] = 32'h3F800000;
        rq_add_b[31:0] = 32'h40000000;
        rq_add_stb[0]  = 1'b1;
        tick();
        chk("s_ack", 32'(rq_add_ack), 32'b001);
        chk("s_ab_stb", 32'(add_ab_stb), 32'd1);
        chk("s_a", add_a, 32'h3F800000);
        chk("s_b", add_b, 32'h40000000);
        rq_add_stb[0] = 1'b0;
        add_ab_ack = 1'b1;
        tick();
        add_ab_ack = 1'b0;
        chk("s_ack_pulse", 32'(rq_add_ack), 32'd0);
        chk("s_ab_drop", 32'(add_ab_stb), 32'd0);
        add_z = 32'h40400000;
        add_z_stb = 1'b1;
        tick();
        add_z_stb = 1'b0;
        chk("s_unit_zack", 32'(add_z_ack), 32'd1);
        chk("s_z", rq_add_z, 32'h40400000);
        chk("s_z_stb", 32'(rq_add_z_stb), 32'b001);
        tick();
        chk("s_unit_zack_pulse", 32'(add_z_ack), 32'd0);
        chk("s_z_stb_hold", 32'(rq_add_z_stb), 32'b001);
        rq_add_z_ack[0] = 1'b1;
        tick();
        rq_add_z_ack = '0;
        chk("s_z_stb_drop", 32'(rq_add_z_stb), 32'd0);

        // Concurrent add (req0) and multiply (req1)
        do_reset();
        rq_add_a[31:0]  = 32'h3F800000;
        rq_add_b[31:0]  = 32'h3F800000;
        rq_add_stb[0]   = 1'b1;
        rq_mul_a[63:32] = 32'h3F636BE3;
        rq_mul_b[63:32] = 32'h40000000;
        rq_mul_stb[1]   = 1'b1;
        tick();
        chk("c_add_ack", 32'(rq_add_ack), 32'b001);
        chk("c_mul_ack", 32'(rq_mul_ack), 32'b010);
        chk("c_mul_gnt", 32'(mul_gnt), 32'd1);
        chk("c_mul_a", mul_a, 32'h3F636BE3);
        chk("c_mul_stb", 32'(mul_ab_stb), 32'd1);
        rq_add_stb = '0;
        rq_mul_stb = '0;
        add_ab_ack = 1'b1;
        mul_ab_ack = 1'b1;
        tick();
        add_ab_ack = 1'b0;
        mul_ab_ack = 1'b0;
        add_z = 32'h40000000; add_z_stb = 1'b1;
        mul_z = 32'h3FE36BE3; mul_z_stb = 1'b1;
        tick();
        add_z_stb = 1'b0;
        mul_z_stb = 1'b0;
        chk("c_add_z", rq_add_z, 32'h40000000);
        chk("c_mul_z", rq_mul_z, 32'h3FE36BE3);
        chk("c_add_z_stb", 32'(rq_add_z_stb), 32'b001);
        chk("c_mul_z_stb", 32'(rq_mul_z_stb), 32'b010);
        rq_add_z_ack[0] = 1'b1;
        rq_mul_z_ack[1] = 1'b1;
        tick();
        rq_add_z_ack = '0;
        rq_mul_z_ack = '0;
        chk("c_mul_z_stb_drop", 32'(rq_mul_z_stb), 32'd0);

        // Round robin with immediate re-requests
        do_reset();
        rq_add_a = {32'h00000102, 32'h00000101, 32'h00000100};
        rq_add_stb = 3'b111;
        for (int i = 0; i < 6; i++) begin
            int g;
            g = i % 3;
            tick();
            chk("rr_ack", 32'(rq_add_ack), 32'(3'b001 << g));
            chk("rr_gnt", 32'(add_gnt), 32'(g));
            chk("rr_a", add_a, 32'h100 + 32'(g));
            rq_add_stb[g] = 1'b0;
            serve_add(g, 32'h1000 + 32'(i));
            rq_add_stb[g] = 1'b1;
        end
        rq_add_stb = '0;

        // Requester 1 stalls Z_ACK while requester 2 waits
        do_reset();
        rq_add_stb = 3'b110;
        tick();
        chk("st_ack1", 32'(rq_add_ack), 32'b010);
        rq_add_stb[1] = 1'b0;
        add_ab_ack = 1'b1;
        tick();
        add_ab_ack = 1'b0;
        add_z = 32'h12345678;
        add_z_stb = 1'b1;
        tick();
        add_z_stb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("st_ab_idle", 32'(add_ab_stb), 32'd0);
            chk("st_z_stb", 32'(rq_add_z_stb), 32'b010);
            tick();
        end
        rq_add_z_ack[1] = 1'b1;
        tick();
        rq_add_z_ack = '0;
        tick();
        chk("st_ack2", 32'(rq_add_ack), 32'b100);
        chk("st_gnt2", 32'(add_gnt), 32'd2);
        rq_add_stb = '0;
        serve_add(2, 32'hCAFE0002);

        // Asynchronous reset in ST_WAIT_Z
        do_reset();
        rq_add_a[95:64] = 32'hDEADBEEF;
        rq_add_stb[2] = 1'b1;
        tick();
        rq_add_stb = '0;
        chk("r_gnt_pre", 32'(add_gnt), 32'd2);
        add_ab_ack = 1'b1;
        tick();
        add_ab_ack = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("r_gnt", 32'(add_gnt), 32'd0);
        chk("r_a", add_a, 32'd0);
        chk("r_ab_stb", 32'(add_ab_stb), 32'd0);
        chk("r_zack", 32'(add_z_ack), 32'd0);
        chk("r_z_stb", 32'(rq_add_z_stb), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        rq_add_a[63:32] = 32'h11111111;
        rq_add_stb[1] = 1'b1;
        tick();
        chk("r_new_ack", 32'(rq_add_ack), 32'b010);
        chk("r_new_a", add_a, 32'h11111111);
        rq_add_stb = '0;
        serve_add(1, 32'h22222222);

        // Unit backpressure: AB_ACK low for 5 cycles
        do_reset();
        rq_add_a[31:0] = 32'hA5A5A5A5;
        rq_add_b[31:0] = 32'h5A5A5A5A;
        rq_add_stb[0] = 1'b1;
        tick();
        rq_add_stb = '0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_stb", 32'(add_ab_stb), 32'd1);
            chk("bp_a", add_a, 32'hA5A5A5A5);
            chk("bp_b", add_b, 32'h5A5A5A5A);
            tick();
        end
        serve_add(0, 32'h33333333);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/float_unit_arbiter.md
# float_unit_arbiter

Shares one `float_adder` and one `float_multiplier` among `N_REQ` filter engines (HPF, LPF, notch) so the ADS1292 filter chain needs a single pair of float units. Each unit has its own independent channel, so an add and a multiply from different requesters can run at the same time. Each channel accepts one operation at a time, grants round-robin, and uses the STB/ACK handshake the float units use, on both its requester side and its unit side.

## Interface
- N_REQ, 3, number of requesters (2..4)
- i_CLK  in  1  clock
- i_RSTN  in  1  reset, asynchronous, active-low; clock i_CLK
- i_RQ_ADD_A  in  32*N_REQ  operand A per requester, slice k = [32k+31:32k]
- i_RQ_ADD_B  in  32*N_REQ  operand B per requester
- i_RQ_ADD_STB  in  N_REQ  requester k operands valid, held until o_RQ_ADD_ACK[k]
- o_RQ_ADD_ACK  out  N_REQ  one-cycle pulse: operands of k captured
- o_RQ_ADD_Z  out  32  result to the granted requester (shared bus)
- o_RQ_ADD_Z_STB  out  N_REQ  result valid for k, held until i_RQ_ADD_Z_ACK[k]
- i_RQ_ADD_Z_ACK  in  N_REQ  requester k took the result
- o_ADD_A, o_ADD_B  out  32 each  operands to float_adder
- o_ADD_AB_STB  out  1  operands valid to adder
- i_ADD_AB_ACK  in  1  adder ready for operands
- i_ADD_Z  in  32  adder result
- i_ADD_Z_STB  in  1  adder result valid
- o_ADD_Z_ACK  out  1  one-cycle pulse: result taken
- o_ADD_GNT  out  2  index of the current or last granted requester
- MUL set: same ports and widths with ADD replaced by MUL (i_RQ_MUL_*, o_RQ_MUL_*, o_MUL_*, i_MUL_*, o_MUL_GNT), connected to float_multiplier

## Operation
- Each channel (ADD, MUL) runs its own FSM and round-robin pointer. The channels never interact.
- ST_ARB
  - If any bit of STB is set, grant the first requester at or after the pointer, wrapping modulo N_REQ.
  - Capture A/B into the unit operand registers, pulse o_RQ_*_ACK[g], set GNT=g, go to ST_ISSUE.
  - With no STB set, stay in ST_ARB.
- ST_ISSUE
  - Hold o_*_AB_STB=1 with the captured operands.
  - On o_*_AB_STB & i_*_AB_ACK: drop STB, go to ST_WAIT_Z.
- ST_WAIT_Z
  - On i_*_Z_STB: latch i_*_Z into o_RQ_*_Z, pulse o_*_Z_ACK for one cycle, go to ST_RETURN.
- ST_RETURN
  - Hold o_RQ_*_Z_STB[g]=1.
  - On i_RQ_*_Z_ACK[g]: drop it, set pointer = (g+1) mod N_REQ, go to ST_ARB.
- At most one bit of o_RQ_*_ACK and of o_RQ_*_Z_STB is ever high per channel.
- Ungranted requesters keep their STB asserted and wait. The block does not drop or queue their requests.
- A requester may have one add and one multiply outstanding at once (HPF step 0 pattern).
- Operands are passed through unmodified. The block does no float arithmetic or sign handling.
- Reset values: all STB/ACK outputs 0, Z and operand buses 32'h0, GNT 0, pointers 0, FSMs ST_ARB.

## Timing
- Grant: STB seen in ST_ARB at edge n, ACK pulse high during cycle n+1, o_*_AB_STB high from cycle n+1.
- Arbitration overhead is 1 cycle before ST_ISSUE, plus 1 cycle after the unit result before the requester sees Z_STB.
- Back-to-back operations cost at least 1 ST_ARB cycle after each requester Z_ACK.
- Simultaneous requests are resolved purely by the pointer. A requester that re-requests immediately after service is lowest priority.
- Requester Z_ACK stall: the channel holds in ST_RETURN and the unit stays idle. The other channel is unaffected.
- STB dropped by a requester before grant: the request is not served and no error is raised.
- Async reset mid-operation: FSMs return to ST_ARB immediately and all handshake outputs go 0.
  - The float units receive the same reset in the top level, so no handshake is left pending.

## Structure
- Shared package / header
  - FSM state encodings: ST_ARB=2'd0, ST_ISSUE=2'd1, ST_WAIT_Z=2'd2, ST_RETURN=2'd3.
  - The 32-bit float width constant.
- One sub-module, `float_rr_channel`, parameterised on N_REQ.
  - It contains the FSM, round-robin pointer and operand/result registers for one unit.
  - The top instantiates it twice (ADD and MUL).
- The float units stay outside this block and are instantiated in the filter top level.

## Test plan
- Single add: req0 A=0x3F800000, B=0x40000000.
  - Required: o_RQ_ADD_ACK[0] pulses once, then o_RQ_ADD_Z=0x40400000 with Z_STB[0] until acked.
- Concurrent channels: req0 add 1.0+1.0, req1 mul 0x3F636BE3×0x40000000, same cycle.
  - Required: both granted in the same cycle, results 0x40000000 and 0x3FE36BE3.
- Round-robin: req0–2 raise add STB together and re-request after each result.
  - Required: grant order 0,1,2,0,1,2 and o_ADD_GNT tracks it.
- Z_ACK stall: req1 delays Z_ACK 10 cycles while req2 is pending.
  - Required: o_ADD_AB_STB stays 0 for those 10 cycles, then req2 is granted.
- Reset mid-operation: assert i_RSTN low in ST_WAIT_Z.
  - Required: all outputs go to reset values immediately.
  - After release, a new request completes normally.
- Unit backpressure: hold i_ADD_AB_ACK=0 for 5 cycles.
  - Required: o_ADD_AB_STB and operands stay stable for those 5 cycles, and the transfer happens on the first cycle AB_ACK=1.
